// File: rtl/vec_cmd_sequencer_if.sv
// CFU command/response handshake plus the datapath control bundle of the vector sequencer.
// Combinational wiring only; no latency of its own.
// Backpressure comes from cmd_ready and rsp_ready, which are carried here.
interface vec_cmd_sequencer_if #(
  parameter int IDX_W = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [9:0]       cmd_payload_function_id;
  logic [31:0]      cmd_payload_inputs_0;
  logic [31:0]      cmd_payload_inputs_1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_payload_outputs_0;
  logic [31:0]      bus_lo;
  logic [IDX_W-1:0] reg_op0_sel;
  logic [IDX_W-1:0] reg_op1_sel;
  logic [IDX_W-1:0] reg_wb_sel;
  logic             reg_load;
  logic             alu_op1_sel;
  logic [1:0]       alu_mode;
  logic [7:0]       alu_imm;
  logic [1:0]       bus_sel;
  logic [2:0]       vlmul;

  // CPU side and datapath stimulus: drives commands and bus data, observes controls
  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
    output rsp_ready, bus_lo,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0,
    input  reg_op0_sel, reg_op1_sel, reg_wb_sel, reg_load,
    input  alu_op1_sel, alu_mode, alu_imm, bus_sel, vlmul
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
    input  rsp_ready, bus_lo,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0,
    output reg_op0_sel, reg_op1_sel, reg_wb_sel, reg_load,
    output alu_op1_sel, alu_mode, alu_imm, bus_sel, vlmul
  );
endinterface

// File: rtl/vec_cmd_sequencer.sv
// Vector CFU command sequencer: owns vlmul, issues one register-group beat per cycle (LMUL beats).
// Latency: accept at cycle 0, beats 1..N, response from N+1; VSETVL/NOP respond at cycle 1.
// Backpressure: one command in flight; cmd_ready low in EXEC/RESP, response held until rsp_ready.
// Optional VSEQ_ALIGN_CHECK_EN: misaligned non-accumulator groups answer FFFF_FFFF with no beats.
module vec_cmd_sequencer #(
  parameter int         NREGS     = 32,
  parameter int         IDX_W     = 5,
  parameter int         CNT_W     = 4,
  parameter logic [2:0] VLMUL_RST = 3'd0
) (
  input logic               clk,
  input logic               reset,
  vec_cmd_sequencer_if.slave cfu
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  localparam logic [2:0] OP_VSETVL = 3'd0;
  localparam logic [2:0] OP_ALUVV  = 3'd1;
  localparam logic [2:0] OP_ALUVI  = 3'd2;
  localparam logic [2:0] OP_MUL    = 3'd3;
  localparam logic [2:0] OP_BACC   = 3'd4;
  localparam logic [2:0] OP_GACC   = 3'd5;

  state_e state_q, state_d;

  logic [2:0]       op_q, op_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       imm_q, imm_d;
  logic [IDX_W-1:0] vd_q, vd_d;
  logic [IDX_W-1:0] vs0_q, vs0_d;
  logic [IDX_W-1:0] vs1_q, vs1_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [31:0]      rsp_q, rsp_d;
  logic [2:0]       vlmul_q, vlmul_d;

  // Decode of the command currently offered
  logic             accept;
  logic [2:0]       cmd_op;
  logic [IDX_W-1:0] cmd_vd, cmd_vs0, cmd_vs1;
  logic             cmd_is_acc;
  logic             cmd_is_exec;
  logic [CNT_W-1:0] lmul_beats;
  logic [CNT_W-1:0] cmd_beats;
  logic             cmd_misalign;
  logic             vset_vill;
  logic [2:0]       vset_vlmul;
  logic             last_beat;

  assign accept      = (state_q == S_IDLE) && cfu.cmd_valid;
  assign cmd_op      = cfu.cmd_payload_function_id[2:0];
  assign cmd_vd      = cfu.cmd_payload_inputs_0[IDX_W-1:0];
  assign cmd_vs0     = cfu.cmd_payload_inputs_0[5 +: IDX_W];
  assign cmd_vs1     = cfu.cmd_payload_inputs_0[10 +: IDX_W];
  assign cmd_is_acc  = (cmd_op == OP_BACC) || (cmd_op == OP_GACC);
  assign cmd_is_exec = (cmd_op >= OP_ALUVV) && (cmd_op <= OP_GACC);
  assign lmul_beats  = CNT_W'(1) << vlmul_q[1:0];
  // Accumulators collapse the group into a single beat regardless of LMUL
  assign cmd_beats   = cmd_is_acc ? CNT_W'(1) : lmul_beats;
  // vtype values 4..7 are illegal: flag vill and fall back to LMUL=1
  assign vset_vill   = cfu.cmd_payload_inputs_0[2];
  assign vset_vlmul  = vset_vill ? 3'd0 : {1'b0, cfu.cmd_payload_inputs_0[1:0]};
  assign last_beat   = (beat_q == last_q);

`ifdef VSEQ_ALIGN_CHECK_EN
  logic [IDX_W-1:0] align_mask;
  assign align_mask   = IDX_W'(lmul_beats - CNT_W'(1));
  assign cmd_misalign = cmd_is_exec && !cmd_is_acc &&
                        (((cmd_vd | cmd_vs0 | cmd_vs1) & align_mask) != '0);
`else
  assign cmd_misalign = 1'b0;
`endif

  // Fields of the command words this block never looks at
  logic unused_bits;
  assign unused_bits = ^{cfu.cmd_payload_function_id[9:5],
                         cfu.cmd_payload_inputs_0[31:10+IDX_W],
                         cfu.cmd_payload_inputs_1[31:8]};

  // Register index of a beat, wrapping modulo the register file size
  function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base,
                                               input logic [CNT_W-1:0] k);
    logic [IDX_W+CNT_W-1:0] sum;
    sum = {{CNT_W{1'b0}}, base} + {{IDX_W{1'b0}}, k};
    return IDX_W'(sum % NREGS);
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: exec ops run their beats, everything else answers immediately
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (cmd_is_exec && !cmd_misalign) ? S_EXEC : S_RESP;
      S_EXEC: if (last_beat) state_d = S_RESP;
      S_RESP: if (cfu.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: latch the command on accept, step beats, capture the result
  always_comb begin
    op_d    = op_q;
    mode_d  = mode_q;
    imm_d   = imm_q;
    vd_d    = vd_q;
    vs0_d   = vs0_q;
    vs1_d   = vs1_q;
    beat_d  = beat_q;
    last_d  = last_q;
    rsp_d   = rsp_q;
    vlmul_d = vlmul_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = cmd_op;
          mode_d = cfu.cmd_payload_function_id[4:3];
          imm_d  = cfu.cmd_payload_inputs_1[7:0];
          vd_d   = cmd_vd;
          vs0_d  = cmd_vs0;
          vs1_d  = cmd_vs1;
          beat_d = '0;
          last_d = cmd_beats - CNT_W'(1);
          if (cmd_op == OP_VSETVL) begin
            vlmul_d = vset_vlmul;
            rsp_d   = {vset_vill, 28'd0, vset_vlmul};
          end else if (cmd_misalign) begin
            rsp_d = 32'hFFFF_FFFF;
          end else begin
            rsp_d = 32'd0;
          end
        end
      end
      S_EXEC: begin
        beat_d = beat_q + CNT_W'(1);
        if (last_beat) rsp_d = cfu.bus_lo;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      mode_q  <= '0;
      imm_q   <= '0;
      vd_q    <= '0;
      vs0_q   <= '0;
      vs1_q   <= '0;
      beat_q  <= '0;
      last_q  <= '0;
      rsp_q   <= '0;
      vlmul_q <= VLMUL_RST;
    end else begin
      op_q    <= op_d;
      mode_q  <= mode_d;
      imm_q   <= imm_d;
      vd_q    <= vd_d;
      vs0_q   <= vs0_d;
      vs1_q   <= vs1_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      rsp_q   <= rsp_d;
      vlmul_q <= vlmul_d;
    end
  end

  assign cfu.vlmul = vlmul_q;

  // Outputs: controls live only in EXEC, response only in RESP, all zero otherwise
  always_comb begin
    cfu.cmd_ready             = 1'b0;
    cfu.rsp_valid             = 1'b0;
    cfu.rsp_payload_outputs_0 = 32'd0;
    cfu.reg_op0_sel           = '0;
    cfu.reg_op1_sel           = '0;
    cfu.reg_wb_sel            = '0;
    cfu.reg_load              = 1'b0;
    cfu.alu_op1_sel           = 1'b0;
    cfu.alu_mode              = 2'd0;
    cfu.alu_imm               = 8'd0;
    cfu.bus_sel               = 2'b00;
    case (state_q)
      S_IDLE: cfu.cmd_ready = 1'b1;
      S_EXEC: begin
        cfu.reg_op0_sel = idx_add(vs0_q, beat_q);
        cfu.reg_op1_sel = idx_add(vs1_q, beat_q);
        cfu.reg_wb_sel  = idx_add(vd_q, beat_q);
        cfu.reg_load    = 1'b1;
        cfu.alu_op1_sel = (op_q == OP_ALUVI);
        cfu.alu_mode    = mode_q;
        cfu.alu_imm     = imm_q;
        case (op_q)
          OP_ALUVV, OP_ALUVI: cfu.bus_sel = 2'b01;
          OP_MUL:             cfu.bus_sel = 2'b10;
          OP_BACC:            cfu.bus_sel = 2'b11;
          default:            cfu.bus_sel = 2'b00;
        endcase
      end
      S_RESP: begin
        cfu.rsp_valid             = 1'b1;
        cfu.rsp_payload_outputs_0 = rsp_q;
      end
      default: ;
    endcase
  end

endmodule
